// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command decoder slice.
package spi_pkg;

    localparam int DEFAULT_ADDR_W   = 7;
    localparam int DEFAULT_NUM_REGS = 16;
    localparam int CMD_RD_BIT       = 7;

    localparam logic [7:0] TX_IDLE = 8'h00;
    localparam logic [7:0] TX_ERR  = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        RD_WAIT,
        READ,
        ERR
    } state_t;

endpackage

// File: rtl/spi_edge_det.sv
// Rising-edge detector: one-cycle pulse when din goes 0->1, none while it stays high.
module spi_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) din_q <= 1'b0;
        else     din_q <= din;
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Decodes one chip-select frame of SPI bytes into register-bank accesses:
// a command byte, then a burst of data (write) or dummy (read) bytes with address auto-increment.
module spi_cmd_decoder
    import spi_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              rx_done,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr_en,
    output logic [7:0]        reg_wdata,
    output logic              reg_rd_en,
    input  logic [7:0]        reg_rdata,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   addr_q, addr_d;   // one spare bit so the increment never wraps
    logic [ADDR_W:0]   addr_inc, cmd_addr;
    logic [7:0]        tx_d, wdata_d;
    logic [ADDR_W-1:0] reg_addr_d;
    logic              wr_d, rd_d, err_d;
    logic              cap_q, cap_d;
    logic              byte_stb;

    spi_edge_det u_rx_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (rx_done),
        .rise (byte_stb)
    );

    function automatic logic in_range(input logic [ADDR_W:0] a);
        return 32'(a) < NUM_REGS_U;
    endfunction

    assign cmd_addr = {1'b0, rx_byte[ADDR_W-1:0]};
    assign addr_inc = addr_q + (ADDR_W+1)'(1);
    assign busy     = (state_q != IDLE);

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        tx_d       = tx_byte;
        reg_addr_d = reg_addr;
        wdata_d    = reg_wdata;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        err_d      = 1'b0;
        cap_d      = 1'b0;

        // Read data arrives the cycle after the strobe; load it one cycle after RD_WAIT.
        if (cap_q) tx_d = reg_rdata;

        if (ss) begin
            state_d = IDLE;
            tx_d    = TX_IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = CMD;
                    tx_d    = TX_IDLE;
                end
                CMD: if (byte_stb) begin
                    addr_d = cmd_addr;
                    if (!in_range(cmd_addr)) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        tx_d    = TX_ERR;
                    end else if (rx_byte[CMD_RD_BIT]) begin
                        state_d    = RD_WAIT;
                        rd_d       = 1'b1;
                        reg_addr_d = cmd_addr[ADDR_W-1:0];
                    end else begin
                        state_d = WRITE;
                    end
                end
                WRITE: if (byte_stb) begin
                    if (in_range(addr_q)) begin
                        wr_d       = 1'b1;
                        wdata_d    = rx_byte;
                        reg_addr_d = addr_q[ADDR_W-1:0];
                        addr_d     = addr_inc;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        tx_d    = TX_ERR;
                    end
                end
                RD_WAIT: begin
                    if (byte_stb) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        tx_d    = TX_ERR;
                    end else begin
                        state_d = READ;
                        cap_d   = 1'b1;
                    end
                end
                READ: if (byte_stb) begin
                    addr_d = addr_inc;
                    if (in_range(addr_inc)) begin
                        state_d    = RD_WAIT;
                        rd_d       = 1'b1;
                        reg_addr_d = addr_inc[ADDR_W-1:0];
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        tx_d    = TX_ERR;
                    end
                end
                ERR: tx_d = TX_ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cap_q     <= 1'b0;
            tx_byte   <= TX_IDLE;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cap_q     <= cap_d;
            tx_byte   <= tx_d;
            reg_addr  <= reg_addr_d;
            reg_wdata <= wdata_d;
            reg_wr_en <= wr_d;
            reg_rd_en <= rd_d;
            frame_err <= err_d;
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench: frame-level reference model schedules expected outputs per cycle.
`timescale 1ns/1ps
module tb_spi_cmd_decoder;

    localparam int ADDR_W   = 7;
    localparam int NUM_REGS = 16;

    logic              clk = 1'b0;
    logic              rst, ss, rx_done;
    logic [7:0]        rx_byte, tx_byte, reg_wdata, reg_rdata;
    logic [ADDR_W-1:0] reg_addr;
    logic              reg_wr_en, reg_rd_en, frame_err, busy;

    always #5 clk = ~clk;

    spi_cmd_decoder #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .clk       (clk),
        .rst       (rst),
        .ss        (ss),
        .rx_done   (rx_done),
        .rx_byte   (rx_byte),
        .tx_byte   (tx_byte),
        .reg_addr  (reg_addr),
        .reg_wr_en (reg_wr_en),
        .reg_wdata (reg_wdata),
        .reg_rd_en (reg_rd_en),
        .reg_rdata (reg_rdata),
        .frame_err (frame_err),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Register bank environment: registered read, preloaded while bank_load is high.
    logic [7:0] bank     [NUM_REGS];
    logic [7:0] init_mem [NUM_REGS];
    logic       bank_load;

    always @(posedge clk) begin
        if (bank_load) begin
            for (int i = 0; i < NUM_REGS; i++) bank[i] <= init_mem[i];
        end else begin
            if (reg_wr_en && reg_addr < NUM_REGS) bank[reg_addr] <= reg_wdata;
            if (reg_rd_en && reg_addr < NUM_REGS) reg_rdata <= bank[reg_addr];
        end
    end

    // Reference model: frame phase plus expected events keyed by cycle.
    typedef enum int {P_IDLE, P_CMD, P_WR, P_RD, P_DEAD} phase_t;
    phase_t     phase;
    int         m_addr, fs, last_rd;
    logic [7:0] mem [NUM_REGS];

    logic [15:0] exp_wr   [int];
    logic [7:0]  exp_rd   [int];
    bit          exp_err  [int];
    logic [7:0]  tx_chg   [int];
    bit          busy_chg [int];

    task automatic purge_after(input int lim, input bit all_maps);
        for (int k = lim + 1; k <= lim + 8; k++) begin
            tx_chg.delete(k);
            if (all_maps) begin
                exp_wr.delete(k);
                exp_rd.delete(k);
                exp_err.delete(k);
                busy_chg.delete(k);
            end
        end
    endtask

    task automatic model_die(input int c);
        exp_err[c+1] = 1'b1;
        tx_chg[c+1]  = 8'hEE;
        phase        = P_DEAD;
    endtask

    task automatic model_read(input int c);
        exp_rd[c+1] = 8'(m_addr);
        tx_chg[c+3] = mem[m_addr];
        last_rd     = c;
        phase       = P_RD;
    endtask

    task automatic model_start(input int c);
        fs            = c;
        last_rd       = -10;
        phase         = P_CMD;
        busy_chg[c+1] = 1'b1;
        tx_chg[c+1]   = 8'h00;
    endtask

    task automatic model_end(input int c);
        purge_after(c + 1, 1'b0);
        phase         = P_IDLE;
        busy_chg[c+1] = 1'b0;
        tx_chg[c+1]   = 8'h00;
    endtask

    task automatic model_reset(input int r);
        purge_after(r, 1'b1);
        tx_chg[r+1]   = 8'h00;
        busy_chg[r+1] = 1'b0;
        model_start(r + 1);
    endtask

    task automatic model_byte(input logic [7:0] b, input int c);
        if (phase == P_IDLE || c <= fs) return;
        case (phase)
            P_CMD: begin
                m_addr = int'(b[6:0]);
                if (m_addr >= NUM_REGS) model_die(c);
                else if (b[7])          model_read(c);
                else                    phase = P_WR;
            end
            P_WR: begin
                if (m_addr >= NUM_REGS) model_die(c);
                else begin
                    exp_wr[c+1] = {8'(m_addr), b};
                    mem[m_addr] = b;
                    m_addr++;
                end
            end
            P_RD: begin
                if (c == last_rd + 1) model_die(c);
                else begin
                    m_addr++;
                    if (m_addr >= NUM_REGS) model_die(c);
                    else                    model_read(c);
                end
            end
            default: ;
        endcase
    endtask

    // Compare process and event logs, both sampled mid-cycle.
    logic [7:0]  cur_tx   = 8'h00;
    bit          cur_busy = 1'b0;
    bit          chk_on   = 1'b0;
    logic [15:0] wr_log [$];
    int          rd_cnt  = 0;
    int          err_cnt = 0;

    always @(negedge clk) begin
        logic [15:0] ew;
        if (chk_on) begin
            if (tx_chg.exists(cyc))   cur_tx   = tx_chg[cyc];
            if (busy_chg.exists(cyc)) cur_busy = busy_chg[cyc];
            check("tx_byte", tx_byte, cur_tx);
            check("busy", busy, cur_busy);
            check("reg_wr_en", reg_wr_en, exp_wr.exists(cyc));
            if (reg_wr_en && exp_wr.exists(cyc)) begin
                ew = exp_wr[cyc];
                check("wr_addr", reg_addr, ew[15:8]);
                check("wr_data", reg_wdata, ew[7:0]);
            end
            check("reg_rd_en", reg_rd_en, exp_rd.exists(cyc));
            if (reg_rd_en && exp_rd.exists(cyc)) check("rd_addr", reg_addr, exp_rd[cyc]);
            check("frame_err", frame_err, exp_err.exists(cyc));
        end
        if (reg_wr_en) wr_log.push_back({1'b0, reg_addr, reg_wdata});
        if (reg_rd_en) rd_cnt++;
        if (frame_err) err_cnt++;
    end

    // Stimulus helpers; inputs change 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        ss = 1'b0;
        model_start(cyc);
        tick();
        tick();
    endtask

    task automatic end_frame();
        ss = 1'b1;
        model_end(cyc);
        tick();
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int low);
        rx_byte = b;
        rx_done = 1'b1;
        model_byte(b, cyc);
        repeat (hold) tick();
        rx_done = 1'b0;
        repeat (low) tick();
    endtask

    task automatic abort_with_byte(input logic [7:0] b, input int hold);
        ss      = 1'b1;
        model_end(cyc);
        rx_byte = b;
        rx_done = 1'b1;
        model_byte(b, cyc);
        repeat (hold) tick();
        rx_done = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base_wr, base_rd, base_err, nb, rdb, a;
        logic [7:0] cmd;

        rst = 1'b1; ss = 1'b1; rx_done = 1'b0; rx_byte = 8'h00; bank_load = 1'b1;
        phase = P_IDLE; fs = 0; last_rd = -10; m_addr = 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            init_mem[i] = 8'($urandom);
            mem[i]      = init_mem[i];
        end
        tick();
        chk_on = 1'b1;
        tick(); tick();
        rst = 1'b0; bank_load = 1'b0;
        tick();

        check("reset_tx", tx_byte, 8'h00);
        check("reset_addr", reg_addr, 0);
        check("reset_wdata", reg_wdata, 8'h00);
        check("reset_strobes", {reg_wr_en, reg_rd_en, frame_err}, 3'b000);
        check("reset_busy", busy, 1'b0);

        // Write burst to addresses 2 and 3.
        base_wr = wr_log.size();
        start_frame();
        send_byte(8'h02, 1, 2);
        send_byte(8'hAB, 2, 2);
        send_byte(8'hCD, 1, 3);
        ss = 1'b1;
        model_end(cyc);
        check("busy_at_ss_rise", busy, 1'b1);
        tick();
        check("busy_after_ss_rise", busy, 1'b0);
        tick();
        check("write_count", wr_log.size() - base_wr, 2);
        check("write0", wr_log[base_wr], 16'h02AB);
        check("write1", wr_log[base_wr + 1], 16'h03CD);

        // Load 0x11/0x22 into 5/6, then read them back as a burst.
        start_frame();
        send_byte(8'h05, 1, 1);
        send_byte(8'h11, 1, 1);
        send_byte(8'h22, 1, 1);
        end_frame();
        base_rd = rd_cnt;
        start_frame();
        send_byte(8'h85, 1, 0);
        tick();
        check("read_tx_before", tx_byte, 8'h00);
        tick();
        check("read_tx_first", tx_byte, 8'h11);
        send_byte(8'h00, 1, 0);
        tick(); tick();
        check("read_tx_second", tx_byte, 8'h22);
        send_byte(8'h00, 1, 3);
        end_frame();
        check("read_count", rd_cnt - base_rd, 3);
        check("tx_after_read_frame", tx_byte, 8'h00);

        // Illegal address: frame dies, later bytes do nothing.
        base_wr = wr_log.size(); base_rd = rd_cnt; base_err = err_cnt;
        start_frame();
        send_byte(8'h10, 1, 1);
        check("illegal_tx", tx_byte, 8'hEE);
        send_byte(8'h00, 1, 2);
        send_byte(8'h55, 1, 2);
        check("illegal_tx_held", tx_byte, 8'hEE);
        end_frame();
        check("illegal_err_count", err_cnt - base_err, 1);
        check("illegal_no_access", (wr_log.size() - base_wr) + (rd_cnt - base_rd), 0);
        check("illegal_tx_idle", tx_byte, 8'h00);

        // Burst overrun off the top of the bank.
        base_wr = wr_log.size(); base_err = err_cnt;
        start_frame();
        send_byte(8'h0F, 1, 1);
        send_byte(8'h31, 1, 1);
        send_byte(8'h32, 1, 2);
        end_frame();
        check("overrun_writes", wr_log.size() - base_wr, 1);
        check("overrun_write0", wr_log[base_wr], 16'h0F31);
        check("overrun_err", err_cnt - base_err, 1);

        // Frame abort on a coincident strobe, then a held rx_done.
        base_wr = wr_log.size();
        start_frame();
        send_byte(8'h04, 1, 2);
        abort_with_byte(8'h77, 10);
        check("abort_no_write", wr_log.size() - base_wr, 0);
        check("abort_busy", busy, 1'b0);
        start_frame();
        send_byte(8'h06, 1, 1);
        send_byte(8'h99, 10, 1);
        end_frame();
        check("held_one_write", wr_log.size() - base_wr, 1);
        check("held_write0", wr_log[base_wr], 16'h0699);

        // Reset while RD_WAIT with ss still low.
        start_frame();
        send_byte(8'h85, 1, 0);
        rst = 1'b1;
        model_reset(cyc);
        tick();
        check("midrst_tx", tx_byte, 8'h00);
        check("midrst_addr", reg_addr, 0);
        check("midrst_wdata", reg_wdata, 8'h00);
        check("midrst_strobes", {reg_wr_en, reg_rd_en, frame_err}, 3'b000);
        check("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        send_byte(8'h03, 1, 1);
        send_byte(8'h5A, 1, 1);
        end_frame();
        check("midrst_write", wr_log[wr_log.size() - 1], 16'h035A);

        // Randomized frames.
        for (int t = 0; t < 150; t++) begin
            start_frame();
            rdb = $urandom_range(0, 1);
            a   = ($urandom_range(0, 5) == 0) ? $urandom_range(16, 19) : $urandom_range(0, 15);
            cmd = {rdb[0], a[6:0]};
            send_byte(cmd, $urandom_range(1, 3), $urandom_range(1, 3));
            nb = $urandom_range(0, 6);
            for (int j = 0; j < nb; j++) begin
                send_byte(8'($urandom), ($urandom_range(0, 7) == 0) ? 12 : $urandom_range(1, 2),
                          $urandom_range(1, 3));
            end
            if ($urandom_range(0, 4) == 0) abort_with_byte(8'($urandom), $urandom_range(1, 4));
            else                           end_frame();
            if ($urandom_range(0, 5) == 0) send_byte(8'($urandom), 1, 1);
        end

        tick(); tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
